// File: rtl/muldiv_control_seq.sv
// Control sequencer for the mul/div datapath: runs one MUL or DIV instruction
// (fetch, operand transfer, clocked ALU, LO/HI writeback) and drives the datapath strobes.
module muldiv_control_seq #(
   parameter logic [4:0] OP_MUL     = 5'b01111,
   parameter logic [4:0] OP_DIV     = 5'b10000,
   parameter int         ALU_CYCLES = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        mem_ready,
   input  logic [31:0] ir,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        pc_enable,
   output logic        pc_out,
   output logic        mar_in,
   output logic        pc_increment,
   output logic        mdr_read,
   output logic        mdr_enable,
   output logic        mdr_out,
   output logic        ir_enable,
   output logic        y_enable,
   output logic        zlo_enable,
   output logic        zhi_enable,
   output logic        zlo_out,
   output logic        zhi_out,
   output logic        lo_enable,
   output logic        hi_enable,
   output logic [15:0] r_out,
   output logic [4:0]  op_code
);

   localparam int ALU_N = (ALU_CYCLES < 1) ? 1 : ALU_CYCLES;
   localparam int CW    = (ALU_N > 1) ? $clog2(ALU_N) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [4:0]    opc_q;
   logic [3:0]    ra_q;
   logic [3:0]    rb_q;
   logic [CW-1:0] alu_cnt;
   logic          legal_op;
   logic          unused_ir;

   assign legal_op  = (opc_q == OP_MUL) || (opc_q == OP_DIV);
   assign unused_ir = ^ir[18:0];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Fields are latched on the edge that enters T3, so later IR changes cannot disturb the instruction.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         opc_q <= '0;
         ra_q  <= '0;
         rb_q  <= '0;
      end else if (state == S_T2) begin
         opc_q <= ir[31:27];
         ra_q  <= ir[26:23];
         rb_q  <= ir[22:19];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         alu_cnt <= '0;
      end else if (state == S_T3) begin
         alu_cnt <= CW'(ALU_N - 1);
      end else if ((state == S_T4) && (alu_cnt != '0)) begin
         alu_cnt <= alu_cnt - CW'(1);
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: if (start)     state_next = S_T0;
         S_T0:                  state_next = S_T1;
         S_T1:   if (mem_ready) state_next = S_T2;
         S_T2:                  state_next = S_T3;
         S_T3:   state_next = legal_op ? S_T4 : S_IDLE;
         S_T4:   if (alu_cnt == '0) state_next = S_T5;
         S_T5:                  state_next = S_T6;
         S_T6:                  state_next = S_DONE;
         S_DONE:                state_next = S_IDLE;
         default:               state_next = S_IDLE;
      endcase
   end

   // Pure state decode; T3 and T4 also use the latched fields, which are registers too.
   always_comb begin
      busy         = (state != S_IDLE);
      done         = 1'b0;
      err          = 1'b0;
      pc_enable    = 1'b0;
      pc_out       = 1'b0;
      mar_in       = 1'b0;
      pc_increment = 1'b0;
      mdr_read     = 1'b0;
      mdr_enable   = 1'b0;
      mdr_out      = 1'b0;
      ir_enable    = 1'b0;
      y_enable     = 1'b0;
      zlo_enable   = 1'b0;
      zhi_enable   = 1'b0;
      zlo_out      = 1'b0;
      zhi_out      = 1'b0;
      lo_enable    = 1'b0;
      hi_enable    = 1'b0;
      r_out        = '0;
      op_code      = '0;
      unique case (state)
         S_T0: begin
            pc_out       = 1'b1;
            mar_in       = 1'b1;
            pc_increment = 1'b1;
         end
         S_T1: begin
            mdr_read   = 1'b1;
            mdr_enable = 1'b1;
         end
         S_T2: begin
            mdr_out   = 1'b1;
            ir_enable = 1'b1;
         end
         S_T3: begin
            if (legal_op) begin
               r_out    = 16'h0001 << ra_q;
               y_enable = 1'b1;
            end else begin
               err = 1'b1;
            end
         end
         S_T4: begin
            r_out      = 16'h0001 << rb_q;
            op_code    = opc_q;
            zlo_enable = 1'b1;
            zhi_enable = 1'b1;
         end
         S_T5: begin
            zlo_out   = 1'b1;
            lo_enable = 1'b1;
         end
         S_T6: begin
            zhi_out   = 1'b1;
            hi_enable = 1'b1;
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_muldiv_control_seq.sv
// Testbench for muldiv_control_seq: two instances (ALU_CYCLES 1 and 4) are checked every
// cycle against an expected strobe trace built from the instruction's opcode, registers and memory wait.
module tb_muldiv_control_seq;

   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;

   localparam logic [38:0] B_BUSY   = 39'd1 << 38;
   localparam logic [38:0] B_DONE   = 39'd1 << 37;
   localparam logic [38:0] B_ERR    = 39'd1 << 36;
   localparam logic [38:0] B_PCOUT  = 39'd1 << 34;
   localparam logic [38:0] B_MARIN  = 39'd1 << 33;
   localparam logic [38:0] B_PCINC  = 39'd1 << 32;
   localparam logic [38:0] B_MDRRD  = 39'd1 << 31;
   localparam logic [38:0] B_MDREN  = 39'd1 << 30;
   localparam logic [38:0] B_MDROUT = 39'd1 << 29;
   localparam logic [38:0] B_IREN   = 39'd1 << 28;
   localparam logic [38:0] B_YEN    = 39'd1 << 27;
   localparam logic [38:0] B_ZLOEN  = 39'd1 << 26;
   localparam logic [38:0] B_ZHIEN  = 39'd1 << 25;
   localparam logic [38:0] B_ZLOOUT = 39'd1 << 24;
   localparam logic [38:0] B_ZHIOUT = 39'd1 << 23;
   localparam logic [38:0] B_LOEN   = 39'd1 << 22;
   localparam logic [38:0] B_HIEN   = 39'd1 << 21;

   logic        clk;
   logic        clr;
   logic        start_v     [2];
   logic        mem_ready_v [2];
   logic [31:0] ir_v        [2];
   logic [38:0] obs         [2];
   int          alu_n       [2];

   int check_count;
   int error_count;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic        busy, done, err, pc_enable, pc_out, mar_in, pc_increment;
      logic        mdr_read, mdr_enable, mdr_out, ir_enable, y_enable;
      logic        zlo_enable, zhi_enable, zlo_out, zhi_out, lo_enable, hi_enable;
      logic [15:0] r_out;
      logic [4:0]  op_code;

      muldiv_control_seq #(
         .OP_MUL     (OP_MUL),
         .OP_DIV     (OP_DIV),
         .ALU_CYCLES ((g == 0) ? 1 : 4)
      ) dut (
         .clk          (clk),
         .clr          (clr),
         .start        (start_v[g]),
         .mem_ready    (mem_ready_v[g]),
         .ir           (ir_v[g]),
         .busy         (busy),
         .done         (done),
         .err          (err),
         .pc_enable    (pc_enable),
         .pc_out       (pc_out),
         .mar_in       (mar_in),
         .pc_increment (pc_increment),
         .mdr_read     (mdr_read),
         .mdr_enable   (mdr_enable),
         .mdr_out      (mdr_out),
         .ir_enable    (ir_enable),
         .y_enable     (y_enable),
         .zlo_enable   (zlo_enable),
         .zhi_enable   (zhi_enable),
         .zlo_out      (zlo_out),
         .zhi_out      (zhi_out),
         .lo_enable    (lo_enable),
         .hi_enable    (hi_enable),
         .r_out        (r_out),
         .op_code      (op_code)
      );

      assign obs[g] = {busy, done, err, pc_enable, pc_out, mar_in, pc_increment,
                       mdr_read, mdr_enable, mdr_out, ir_enable, y_enable,
                       zlo_enable, zhi_enable, zlo_out, zhi_out, lo_enable, hi_enable,
                       r_out, op_code};
   end

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [38:0] observed, input logic [38:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [38:0] reg_sel(input logic [3:0] r);
      logic [15:0] oh;
      oh = 16'h0001 << r;
      return 39'(oh) << 5;
   endfunction

   // Runs one instruction on instance sel, starting from a negedge while that instance is idle.
   // delay = number of T1 cycles with mem_ready low; abort_k = trace index at which clr is pulsed (-1 none).
   task automatic applyStimulus(input int sel, input logic [4:0] op, input logic [3:0] ra,
                                input logic [3:0] rb, input int delay, input bit hold, input int abort_k);
      logic [38:0] exp_q [$];
      bit          legal;
      legal = (op == OP_MUL) || (op == OP_DIV);
      exp_q.push_back(B_BUSY | B_PCOUT | B_MARIN | B_PCINC);
      repeat (delay + 1) exp_q.push_back(B_BUSY | B_MDRRD | B_MDREN);
      exp_q.push_back(B_BUSY | B_MDROUT | B_IREN);
      if (legal) begin
         exp_q.push_back(B_BUSY | B_YEN | reg_sel(ra));
         repeat (alu_n[sel]) exp_q.push_back(B_BUSY | B_ZLOEN | B_ZHIEN | reg_sel(rb) | 39'(op));
         exp_q.push_back(B_BUSY | B_ZLOOUT | B_LOEN);
         exp_q.push_back(B_BUSY | B_ZHIOUT | B_HIEN);
         exp_q.push_back(B_BUSY | B_DONE);
      end else begin
         exp_q.push_back(B_BUSY | B_ERR);
      end

      ir_v[sel]        = {op, ra, rb, 19'($urandom)};
      start_v[sel]     = 1'b1;
      mem_ready_v[sel] = 1'($urandom);
      for (int k = 0; k < exp_q.size(); k++) begin
         int c;
         c = k + 1;
         @(negedge clk);
         checkOutput($sformatf("dut%0d_op%h_c%0d", sel, op, c), obs[sel], exp_q[k]);
         checkOutput($sformatf("dut%0d_quiet_c%0d", 1 - sel, c), obs[1 - sel], '0);
         start_v[sel] = hold ? 1'b1 : 1'($urandom);
         if (c >= 2 && c <= 2 + delay) mem_ready_v[sel] = (c == 2 + delay);
         else                          mem_ready_v[sel] = 1'($urandom);
         if (c >= 4 + delay) ir_v[sel] = $urandom;
         if (k == abort_k) begin
            start_v[sel] = 1'b0;
            #3 clr = 1'b0;
            #1;
            checkOutput($sformatf("dut%0d_clr_async", sel), obs[sel], '0);
            checkOutput($sformatf("dut%0d_clr_async", 1 - sel), obs[1 - sel], '0);
            @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("dut%0d_after_clr", sel), obs[sel], '0);
            return;
         end
      end
   endtask

   task automatic checkIdle(input int sel, input bit next_start);
      @(negedge clk);
      checkOutput($sformatf("dut%0d_idle", sel), obs[sel], '0);
      start_v[sel] = next_start;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      check_count = 0;
      error_count = 0;
      alu_n[0]    = 1;
      alu_n[1]    = 4;
      clr         = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_v[i]     = 1'b0;
         mem_ready_v[i] = 1'b0;
         ir_v[i]        = '0;
      end
      #2;
      checkOutput("reset_dut0", obs[0], '0);
      checkOutput("reset_dut1", obs[1], '0);
      @(negedge clk);
      clr = 1'b1;
      checkIdle(0, 1'b0);

      $display("[TB] directed: mul, div with memory wait, long ALU, illegal opcode");
      applyStimulus(0, OP_MUL, 4'd6, 4'd7, 0, 1'b0, -1);
      checkIdle(0, 1'b0);
      applyStimulus(0, OP_DIV, 4'd7, 4'd6, 3, 1'b0, -1);
      checkIdle(0, 1'b0);
      applyStimulus(1, OP_MUL, 4'd3, 4'd12, 1, 1'b0, -1);
      checkIdle(1, 1'b0);
      applyStimulus(1, OP_DIV, 4'd15, 4'd0, 0, 1'b0, -1);
      checkIdle(1, 1'b0);
      applyStimulus(0, 5'b00011, 4'd2, 4'd5, 0, 1'b0, -1);
      checkIdle(0, 1'b0);
      applyStimulus(1, 5'b00011, 4'd8, 4'd1, 2, 1'b0, -1);
      checkIdle(1, 1'b0);
      applyStimulus(0, OP_MUL, 4'd9, 4'd9, 1, 1'b0, -1);
      checkIdle(0, 1'b0);

      $display("[TB] directed: clr during T4");
      applyStimulus(0, OP_MUL, 4'd1, 4'd2, 0, 1'b0, 4);
      applyStimulus(1, OP_DIV, 4'd4, 4'd5, 2, 1'b0, 7);

      $display("[TB] directed: start held high");
      applyStimulus(0, OP_MUL, 4'd10, 4'd11, 0, 1'b1, -1);
      checkIdle(0, 1'b1);
      applyStimulus(0, OP_DIV, 4'd12, 4'd13, 1, 1'b1, -1);
      checkIdle(0, 1'b1);
      applyStimulus(0, OP_MUL, 4'd14, 4'd0, 0, 1'b1, -1);
      checkIdle(0, 1'b0);

      $display("[TB] random instructions");
      for (int n = 0; n < 40; n++) begin
         int          sel;
         int          pick;
         logic [4:0]  op;
         sel  = int'($urandom_range(0, 1));
         pick = int'($urandom_range(0, 9));
         if (pick < 4)      op = OP_MUL;
         else if (pick < 8) op = OP_DIV;
         else               op = 5'($urandom);
         applyStimulus(sel, op, 4'($urandom), 4'($urandom), int'($urandom_range(0, 4)),
                       1'($urandom), -1);
         checkIdle(sel, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
